// File: rtl/ser_par_gearbox.sv
// ser_par_gearbox
//   Bidirectional lane gearbox between a LANES*LANE_W parallel word and a
//   LANE_W serial lane stream. One direction is active per word:
//     mode=0  parallel-to-serial (P2S): one word in, LANES beats out
//     mode=1  serial-to-parallel (S2P): LANES beats in, one word out
//   mode and msb_first are latched when a word starts and are ignored until
//   the machine is back in IDLE.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   mode           0 = P2S, 1 = S2P (sampled at word start)
//   msb_first      1 = top lane first, 0 = lane 0 first (sampled at word start)
//   p_in_*         P2S parallel input  (valid/ready/data)
//   s_out_*        P2S serial output   (valid/ready/data/last)
//   s_in_*         S2P serial input    (valid/ready/data)
//   p_out_*        S2P parallel output (valid/ready/data)
//   busy           high whenever the FSM is not in IDLE
//
// State table
//   state   | meaning
//   IDLE    | no word in flight; ready follows the live mode input
//   SHIFT   | P2S word loaded; emitting lane cnt in the latched order
//   COLLECT | S2P word partially assembled; cnt lanes written so far
//   HOLD    | S2P word complete; presented on p_out_data until taken

module ser_par_gearbox #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      msb_first,

  input  logic                      p_in_valid,
  output logic                      p_in_ready,
  input  logic [LANES*LANE_W-1:0]   p_in_data,

  output logic                      s_out_valid,
  input  logic                      s_out_ready,
  output logic [LANE_W-1:0]         s_out_data,
  output logic                      s_out_last,

  input  logic                      s_in_valid,
  output logic                      s_in_ready,
  input  logic [LANE_W-1:0]         s_in_data,

  output logic                      p_out_valid,
  input  logic                      p_out_ready,
  output logic [LANES*LANE_W-1:0]   p_out_data,

  output logic                      busy
);

  localparam int WORD_W = LANES * LANE_W;
  localparam int CW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                msb_q;
  logic [WORD_W-1:0]   shreg;
  logic [WORD_W-1:0]   col;

  logic [CW-1:0]       cnt_inc;
  logic                cnt_last;
  logic                p_acc;
  logic                s_acc;
  logic [CW-1:0]       s_wr_idx;
  logic [LANE_W-1:0]   first_lane;

  // Physical lane for the c-th beat of a word in the given order.
  function automatic logic [CW-1:0] lane_idx(input logic [CW-1:0] c,
                                             input logic          msb);
    return msb ? (CNT_MAX - c) : c;
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] w,
                                                input logic [CW-1:0]     idx);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == CW'(i)) r = w[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  assign cnt_inc  = cnt + CW'(1);
  assign cnt_last = (cnt == CNT_MAX);

  // A new P2S word may enter from IDLE, or on the final beat of the current
  // word so that back-to-back words stream with no bubble.
  assign p_in_ready = !mode &&
                      ((state == IDLE) ||
                       ((state == SHIFT) && cnt_last && s_out_ready));

  assign s_in_ready = ((state == IDLE) && mode) || (state == COLLECT);

  assign p_acc = p_in_valid && p_in_ready;
  assign s_acc = s_in_valid && s_in_ready;

  // The first S2P beat is placed with the live msb_first; later beats use
  // the latched copy.
  assign s_wr_idx   = (state == IDLE) ? lane_idx('0, msb_first)
                                      : lane_idx(cnt, msb_q);
  assign first_lane = lane_of(p_in_data, lane_idx('0, msb_first));

  assign busy       = (state != IDLE);
  assign p_out_data = col;

  // The active direction is implied by the state (SHIFT vs COLLECT/HOLD),
  // so only msb_first needs an explicit latched copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      msb_q       <= 1'b0;
      shreg       <= '0;
      col         <= '0;
      s_out_data  <= '0;
      s_out_valid <= 1'b0;
      s_out_last  <= 1'b0;
      p_out_valid <= 1'b0;
    end else begin
      if (p_acc) begin
        state       <= SHIFT;
        shreg       <= p_in_data;
        msb_q       <= msb_first;
        cnt         <= '0;
        s_out_data  <= first_lane;
        s_out_valid <= 1'b1;
        s_out_last  <= (CNT_MAX == '0);
      end else begin
        case (state)
          IDLE: begin
            if (s_acc) begin
              state <= COLLECT;
              msb_q <= msb_first;
              cnt   <= CW'(1);
            end
          end

          SHIFT: begin
            if (s_out_ready) begin
              if (cnt_last) begin
                state       <= IDLE;
                s_out_valid <= 1'b0;
                s_out_last  <= 1'b0;
              end else begin
                cnt        <= cnt_inc;
                s_out_data <= lane_of(shreg, lane_idx(cnt_inc, msb_q));
                s_out_last <= (cnt_inc == CNT_MAX);
              end
            end
          end

          COLLECT: begin
            if (s_in_valid) begin
              if (cnt_last) begin
                state       <= HOLD;
                p_out_valid <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end

          HOLD: begin
            if (p_out_ready) begin
              state       <= IDLE;
              p_out_valid <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end

      if (s_acc) begin
        for (int i = 0; i < LANES; i++) begin
          if (s_wr_idx == CW'(i)) col[i*LANE_W +: LANE_W] <= s_in_data;
        end
      end
    end
  end

endmodule

// File: doc/ser_par_gearbox.md
SER_PAR_GEARBOX -- requirements
Module: ser_par_gearbox

Interface
REQ-001 SHALL have parameter LANE_W, default 8, serial lane width in bits.
REQ-002 SHALL have parameter LANES, default 4, number of lanes per parallel word (>=2).
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port mode  in  1  0 = parallel-to-serial (P2S), 1 = serial-to-parallel (S2P).
REQ-006 SHALL have port msb_first  in  1  1 = lane LANES-1 (top bits) first, 0 = lane 0 first.
REQ-007 SHALL have ports p_in_valid in 1, p_in_ready out 1, p_in_data in LANES*LANE_W; this is the P2S parallel input.
REQ-008 SHALL have ports s_out_valid out 1, s_out_ready in 1, s_out_data out LANE_W, s_out_last out 1; this is the P2S serial output.
REQ-009 SHALL have ports s_in_valid in 1, s_in_ready out 1, s_in_data in LANE_W; this is the S2P serial input.
REQ-010 SHALL have ports p_out_valid out 1, p_out_ready in 1, p_out_data out LANES*LANE_W; this is the S2P parallel output.
REQ-011 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-012 SHALL implement a state machine with states IDLE, SHIFT (P2S), COLLECT (S2P), HOLD (S2P word ready).
REQ-013 SHALL sample mode and msb_first only on the cycle a word starts (P2S load or first S2P beat) and hold the latched copy until return to IDLE; changes while busy have no effect.
REQ-014 A transfer occurs only when valid and ready are both high at a rising edge; valid/ready SHALL NOT be gated by each other.
REQ-015 P2S: p_in_ready=1 in IDLE with mode=0; an accepted word loads the shift register, clears lane counter cnt, and moves to SHIFT.
REQ-016 SHIFT: s_out_valid=1; s_out_data = lane cnt counted in the latched order; s_out_data is held stable while s_out_ready=0.
REQ-017 SHIFT: each accepted beat increments cnt; s_out_last=1 exactly when cnt==LANES-1.
REQ-018 On the last accepted beat, SHALL go to IDLE, except when p_in_ready is also high and p_in_valid=1.
REQ-019 On the last beat, p_in_ready SHALL be high combinationally when s_out_ready=1 and mode=0; a word accepted then reloads and stays in SHIFT with no bubble.
REQ-020 S2P: s_in_ready=1 in IDLE with mode=1 and in COLLECT; a beat accepted in IDLE moves to COLLECT.
REQ-021 Each accepted S2P beat writes lane cnt in the latched order and increments cnt.
REQ-022 The LANES-th accepted S2P beat moves to HOLD; p_out_valid=1 on the next cycle (one-cycle latency) with the full word on p_out_data.
REQ-023 HOLD: s_in_ready=0; p_out_data is held stable until p_out_ready=1, then SHALL go to IDLE.
REQ-024 cnt SHALL be $clog2(LANES) bits wide and SHALL never exceed LANES-1; there is no wrap other than the reset to 0 at word start.
REQ-025 Outside their valid cycles, s_out_data and p_out_data SHALL hold their last register values; they are don't-care to consumers.

Reset
REQ-026 rst=1 SHALL force state IDLE and cnt=0, clear the data registers and latched mode/msb_first to 0, and drive s_out_valid, s_out_last, p_out_valid and busy to 0.
REQ-027 rst asserted mid-SHIFT or mid-COLLECT SHALL discard the partial word with no further output beats; p_in_ready/s_in_ready SHALL follow the mode input from the first cycle after rst deasserts.

Verification
REQ-028 P2S, LANE_W=8, LANES=4, msb_first=1, s_out_ready=1, load 0xA1B2C3D4 -> s_out_data A1,B2,C3,D4 on 4 consecutive cycles; s_out_last only with D4.
REQ-029 P2S msb_first=0, same word -> D4,C3,B2,A1; then msb_first toggled mid-word -> order unchanged.
REQ-030 P2S backpressure: s_out_ready=0 for 3 cycles on beat 2 -> B2 held for 4 cycles, total 7 cycles; two back-to-back words with p_in_valid=1 -> 8 beats in 8 cycles, busy never drops.
REQ-031 S2P msb_first=1, beats 11,22,33,44 -> p_out_valid one cycle after the 44 beat with p_out_data=0x11223344; p_out_ready=0 for 2 cycles -> s_in_ready=0 and data stable; msb_first=0 -> 0x44332211.
REQ-032 Reset after 2 P2S beats -> next cycle busy=0, s_out_valid=0; the next load 0x01020304 outputs 01,02,03,04 correctly.
